clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-set and alarm controller for the 6-bit seconds/minutes/hours time-of-day counter. It sequences the counter between running and editing, and owns shadow hour/minute registers edited by button pulses. It commits edited time to the counter through a one-cycle load strobe and raises an alarm on a programmed hour:minute match. It sits between the button synchronizers and the counter's enable/load inputs.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles in any edit state before abandoning the edit.
- `BLINK_DIV`, default 250: cycles per half-period of the `blink` output.
- `ALARM_CYCLES`, default 600: maximum number of cycles `alarm` stays high.
- `clk` input, 1 bit: single clock; all state changes on rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `mode_pulse` input, 1 bit: single-cycle pulse that advances the set-time sequence.
- `alm_pulse` input, 1 bit: single-cycle pulse that advances the alarm-set sequence.
- `inc_pulse` input, 1 bit: single-cycle pulse that increments the field being edited.
- `sec_in`, `min_in`, `hr_in` inputs, 6 bits each: current counter value.
- `cnt_en` output, 1 bit: counter run enable.
- `load` output, 1 bit: one-cycle strobe; counter takes `load_hr`/`load_min` and seconds = 0.
- `load_hr`, `load_min` outputs, 6 bits each: shadow values; valid when `load` is high.
- `edit_field` output, 2 bits: field being edited. 0 = none, 1 = hours, 2 = minutes.
- `blink` output, 1 bit: display blink for the edited field; 0 outside edit states.
- `alarm` output, 1 bit: alarm active.
- `alm_armed` output, 1 bit: alarm enabled.

## Operation
- States: RUN, SET_HR, SET_MIN, COMMIT, ALM_HR, ALM_MIN.
- RUN:
  - `mode_pulse` → SET_HR; shadow registers are copied from `hr_in`/`min_in` on this transition.
  - `alm_pulse` → ALM_HR.
- SET_HR: `inc_pulse` increments shadow hour, 23 wraps to 0. `mode_pulse` → SET_MIN.
- SET_MIN: `inc_pulse` increments shadow minute, 59 wraps to 0. `mode_pulse` → COMMIT.
- COMMIT: lasts exactly one cycle. `load` = 1, then → RUN.
- ALM_HR and ALM_MIN edit alarm hour and alarm minute directly, with the same wrap rules.
  - `alm_pulse` in ALM_HR → ALM_MIN.
  - `alm_pulse` in ALM_MIN → RUN and sets `alm_armed` = 1.
- `alm_armed` is cleared by `alm_pulse` in RUN only while `alarm` = 1.
- `cnt_en` = 1 in RUN and COMMIT, 0 in all other states. The counter holds its value while time or alarm is being edited.
- Idle timeout: in any edit state, after `TIMEOUT_CYCLES` consecutive cycles with no pulse input → RUN.
  - No `load` is issued.
  - Shadow edits are discarded.
  - Partial alarm edits are kept, but `alm_armed` is unchanged.
- Simultaneous pulses, priority order:
  - A mode or alarm pulse beats `inc_pulse`; the increment is dropped.
  - In RUN, `mode_pulse` beats `alm_pulse`.
  - In an edit state, only that sequence's advance pulse counts; the other sequence's pulse is ignored but still resets the idle timer.
- Alarm:
  - Trigger: `alm_armed` = 1, state RUN, `hr_in` == alarm hour, `min_in` == alarm minute, and `sec_in` == 0.
  - On trigger, `alarm` rises on the next cycle.
  - `alarm` clears after `ALARM_CYCLES` cycles, or one cycle after any pulse input.
  - It does not retrigger within the same minute.
- Out-of-range inputs (`hr_in` > 23, `min_in` > 59) copied into shadow are clamped to 0 before editing.

## Timing
- Reset values:
  - State RUN.
  - `cnt_en` = 1.
  - `load` = 0.
  - `load_hr` = `load_min` = 0.
  - `edit_field` = 0, `blink` = 0, `alarm` = 0, `alm_armed` = 0.
  - Alarm hour and minute = 0.
  - Idle and blink counters = 0.
- All outputs are registered.
- Latencies:
  - A pulse at edge N changes state/field at edge N+1.
  - `load` is high for one cycle, one edge after the `mode_pulse` that left SET_MIN.
  - `cnt_en` drops in the same cycle SET_HR is entered.
  - `cnt_en` rises in the COMMIT cycle.
- Blink counter resets on entry to any edit state. `blink` starts at 1 and toggles every `BLINK_DIV` cycles.
- Reset asserted mid-edit: immediate return to RUN. No `load` is issued; the shadow registers are lost.

## Structure
- Shared package `clock_pkg`:
  - State enum.
  - `TIME_W` = 6, `MAX_HR` = 23, `MAX_MIN` = 59.
  - `edit_field` encodings.
- One sub-module, `clock_idle_timer`: a counter with clear, enable and a terminal pulse. It is instantiated twice, once for the idle timeout and once for the alarm duration.
- Modulo-increment logic stays inline as a function in `clock_pkg`.

## Test plan
- **Set time:** `TIMEOUT_CYCLES` = 16. Counter at 10:15:xx; `mode_pulse`, 3× `inc_pulse`, `mode_pulse`, 2× `inc_pulse`, `mode_pulse`. Expect one `load` with `load_hr` = 13, `load_min` = 17; `cnt_en` low from SET_HR entry until COMMIT.
- **Wrap:** shadow hour 23 + `inc_pulse` → 0; shadow minute 59 + `inc_pulse` → 0; `hr_in` = 30 at entry → shadow hour 0.
- **Timeout:** in SET_MIN, idle 16 cycles. Expect return to RUN with no `load`, `cnt_en` = 1, `edit_field` = 0.
- **Alarm:** program alarm 7:30, counter reaches 7:30:00. Expect `alarm` = 1 the next cycle, low after `ALARM_CYCLES`, and no retrigger at 7:30:01.
- **Alarm dismiss:** `alm_pulse` while `alarm` = 1 → `alarm` = 0 and `alm_armed` = 0.
- **Collision and reset:** `mode_pulse` with `inc_pulse` in SET_HR → SET_MIN with hour unchanged. `rst` low mid-SET_MIN → all outputs at reset values, state RUN.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, widths and helpers for the time-of-day set/alarm controller.
package clock_pkg;

    localparam int unsigned TIME_W  = 6;
    localparam int unsigned MAX_HR  = 23;
    localparam int unsigned MAX_MIN = 59;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HR,
        ST_SET_MIN,
        ST_COMMIT,
        ST_ALM_HR,
        ST_ALM_MIN
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HR   = 2'd1,
        FIELD_MIN  = 2'd2
    } field_e;

    function automatic logic [TIME_W-1:0] inc_mod(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] max_v);
        return (v >= max_v) ? '0 : v + TIME_W'(1);
    endfunction

    function automatic logic [TIME_W-1:0] clamp(input logic [TIME_W-1:0] v,
                                                input logic [TIME_W-1:0] max_v);
        return (v > max_v) ? '0 : v;
    endfunction

    function automatic logic is_edit(input state_e s);
        return (s == ST_SET_HR) || (s == ST_SET_MIN) ||
               (s == ST_ALM_HR) || (s == ST_ALM_MIN);
    endfunction

endpackage

// File: rtl/clock_idle_timer.sv
// Cycle counter with clear and enable; done_o marks the LIMIT-th enabled cycle.
module clock_idle_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign done_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/edit sequencer for the time-of-day counter: shadow time editing with a
// one-cycle commit strobe, alarm programming and hour:minute alarm matching.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned BLINK_DIV      = 250,
    parameter int unsigned ALARM_CYCLES   = 600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_pulse,
    input  logic              alm_pulse,
    input  logic              inc_pulse,
    input  logic [TIME_W-1:0] sec_in,
    input  logic [TIME_W-1:0] min_in,
    input  logic [TIME_W-1:0] hr_in,
    output logic              cnt_en,
    output logic              load,
    output logic [TIME_W-1:0] load_hr,
    output logic [TIME_W-1:0] load_min,
    output logic [1:0]        edit_field,
    output logic              blink,
    output logic              alarm,
    output logic              alm_armed
);

    localparam logic [TIME_W-1:0] HR_TOP  = TIME_W'(MAX_HR);
    localparam logic [TIME_W-1:0] MIN_TOP = TIME_W'(MAX_MIN);
    localparam int unsigned       BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_DIV - 1);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] shadow_hr_q, shadow_hr_d;
    logic [TIME_W-1:0] shadow_min_q, shadow_min_d;
    logic [TIME_W-1:0] alm_hr_q, alm_hr_d;
    logic [TIME_W-1:0] alm_min_q, alm_min_d;
    logic              armed_q, armed_d;
    logic              alarm_q, alarm_d;
    logic              fired_q, fired_d;
    logic              cnt_en_q, cnt_en_d;
    logic              load_q, load_d;
    field_e            field_q, field_d;
    logic              blink_q, blink_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;

    logic any_pulse, inc_ok, edit_now;
    logic idle_done, alarm_done;
    logic alarm_match, trigger;

    assign any_pulse   = mode_pulse | alm_pulse | inc_pulse;
    assign inc_ok      = inc_pulse & ~mode_pulse & ~alm_pulse;
    assign edit_now    = is_edit(state_q);
    assign alarm_match = (hr_in == alm_hr_q) && (min_in == alm_min_q);
    assign trigger     = armed_q && (state_q == ST_RUN) && alarm_match &&
                         (sec_in == '0) && !fired_q && !alarm_q;

    clock_idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (any_pulse | ~edit_now),
        .en_i   (edit_now),
        .done_o (idle_done)
    );

    clock_idle_timer #(.LIMIT(ALARM_CYCLES)) u_alarm_timer (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (~alarm_q),
        .en_i   (alarm_q),
        .done_o (alarm_done)
    );

    always_comb begin
        state_d      = state_q;
        shadow_hr_d  = shadow_hr_q;
        shadow_min_d = shadow_min_q;
        alm_hr_d     = alm_hr_q;
        alm_min_d    = alm_min_q;
        armed_d      = armed_q;

        case (state_q)
            ST_RUN: begin
                if (mode_pulse) begin
                    state_d      = ST_SET_HR;
                    shadow_hr_d  = clamp(hr_in, HR_TOP);
                    shadow_min_d = clamp(min_in, MIN_TOP);
                end else if (alm_pulse) begin
                    // A pulse while ringing dismisses the alarm instead of starting an edit.
                    if (alarm_q) armed_d = 1'b0;
                    else         state_d = ST_ALM_HR;
                end
            end
            ST_SET_HR: begin
                if (mode_pulse)     state_d = ST_SET_MIN;
                else if (inc_ok)    shadow_hr_d = inc_mod(shadow_hr_q, HR_TOP);
                else if (idle_done) state_d = ST_RUN;
            end
            ST_SET_MIN: begin
                if (mode_pulse)     state_d = ST_COMMIT;
                else if (inc_ok)    shadow_min_d = inc_mod(shadow_min_q, MIN_TOP);
                else if (idle_done) state_d = ST_RUN;
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            ST_ALM_HR: begin
                if (alm_pulse)      state_d = ST_ALM_MIN;
                else if (inc_ok)    alm_hr_d = inc_mod(alm_hr_q, HR_TOP);
                else if (idle_done) state_d = ST_RUN;
            end
            ST_ALM_MIN: begin
                if (alm_pulse) begin
                    state_d = ST_RUN;
                    armed_d = 1'b1;
                end else if (inc_ok) begin
                    alm_min_d = inc_mod(alm_min_q, MIN_TOP);
                end else if (idle_done) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cnt_en_d = (state_d == ST_RUN) || (state_d == ST_COMMIT);
        load_d   = (state_d == ST_COMMIT);
        case (state_d)
            ST_SET_HR, ST_ALM_HR:   field_d = FIELD_HR;
            ST_SET_MIN, ST_ALM_MIN: field_d = FIELD_MIN;
            default:                field_d = FIELD_NONE;
        endcase

        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (!is_edit(state_d)) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (state_d != state_q) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        alarm_d = alarm_q;
        if (alarm_q && (any_pulse || alarm_done)) alarm_d = 1'b0;
        else if (trigger)                         alarm_d = 1'b1;

        // Latch stays set until the counter leaves the alarm minute, blocking retrigger.
        fired_d = fired_q;
        if (trigger)           fired_d = 1'b1;
        else if (!alarm_match) fired_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            shadow_hr_q  <= '0;
            shadow_min_q <= '0;
            alm_hr_q     <= '0;
            alm_min_q    <= '0;
            armed_q      <= 1'b0;
            alarm_q      <= 1'b0;
            fired_q      <= 1'b0;
            cnt_en_q     <= 1'b1;
            load_q       <= 1'b0;
            field_q      <= FIELD_NONE;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            shadow_hr_q  <= shadow_hr_d;
            shadow_min_q <= shadow_min_d;
            alm_hr_q     <= alm_hr_d;
            alm_min_q    <= alm_min_d;
            armed_q      <= armed_d;
            alarm_q      <= alarm_d;
            fired_q      <= fired_d;
            cnt_en_q     <= cnt_en_d;
            load_q       <= load_d;
            field_q      <= field_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign cnt_en     = cnt_en_q;
    assign load       = load_q;
    assign load_hr    = shadow_hr_q;
    assign load_min   = shadow_min_q;
    assign edit_field = field_q;
    assign blink      = blink_q;
    assign alarm      = alarm_q;
    assign alm_armed  = armed_q;

endmodule
